// File: rtl/dmem_unit_if.sv
// Load/store bus between a core and dmem_unit.
// The master drives the strobes, address, data and type; the slave returns the load result.
interface dmem_unit_if;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output mem_w, mem_r, addr, wdata, dm_type,
    input  rdata, rvalid
  );

  modport slave (
    input  mem_w, mem_r, addr, wdata, dm_type,
    output rdata, rvalid
  );
endinterface

// File: rtl/dmem_unit.sv
// Byte-addressable data memory with sized/signed loads, write-first collisions and saturating access counters.
// Define DMEM_MISALIGN_CHK_EN to suppress misaligned accesses and report them on mis_err/mis_addr.
module dmem_unit #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  dmem_unit_if.slave            bus,
  input  logic [DEPTH_LOG2-1:0] dbg_sel,
  output logic [31:0]           dbg_data,
  output logic [CNT_W-1:0]      ld_cnt,
  output logic [CNT_W-1:0]      st_cnt
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic                  mis_err,
  output logic [31:0]           mis_addr
`endif
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [2:0]  T_HALF  = 3'd1;
  localparam logic [2:0]  T_HALFU = 3'd2;
  localparam logic [2:0]  T_BYTE  = 3'd3;
  localparam logic [2:0]  T_BYTEU = 3'd4;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [1:0]            lane_c;
  logic                  is_half_c;
  logic                  is_byte_c;
  logic                  st_legal_c;
  logic                  misalign_c;
  logic                  st_en_c;
  logic [31:0]           old_word_c;
  logic [31:0]           merged_c;
  logic [31:0]           src_word_c;
  logic [31:0]           ld_data_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  logic [CNT_W-1:0]      ld_cnt_q;
  logic [CNT_W-1:0]      st_cnt_q;
  logic                  unused_addr_c;

  // Upper address bits fold away: the array wraps modulo its size.
  assign idx_c         = bus.addr[DEPTH_LOG2+1:2];
  assign lane_c        = bus.addr[1:0];
  assign unused_addr_c = ^bus.addr[31:DEPTH_LOG2+2];

  assign is_half_c  = (bus.dm_type == T_HALF) || (bus.dm_type == T_HALFU);
  assign is_byte_c  = (bus.dm_type == T_BYTE) || (bus.dm_type == T_BYTEU);
  assign st_legal_c = (bus.dm_type <= T_BYTEU);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign_c = is_half_c ? lane_c[0] : (!is_byte_c && (lane_c != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign st_en_c    = bus.mem_w && st_legal_c && !misalign_c;
  assign old_word_c = mem_q[idx_c];
  assign dbg_data   = mem_q[dbg_sel];

  // Lane merge of the store data into the addressed word.
  always_comb begin
    merged_c = old_word_c;
    if (is_byte_c) begin
      merged_c[{lane_c, 3'b000} +: 8] = bus.wdata[7:0];
    end else if (is_half_c) begin
      merged_c[{lane_c[1], 4'b0000} +: 16] = bus.wdata[15:0];
    end else begin
      merged_c = bus.wdata;
    end
  end

  // Write-first: a load colliding with a store sees the merged word.
  assign src_word_c = st_en_c ? merged_c : old_word_c;

  always_comb begin
    byte_c = src_word_c[{lane_c, 3'b000} +: 8];
    half_c = src_word_c[{lane_c[1], 4'b0000} +: 16];
    case (bus.dm_type)
      T_HALF:  ld_data_c = {{16{half_c[15]}}, half_c};
      T_HALFU: ld_data_c = {16'h0000, half_c};
      T_BYTE:  ld_data_c = {{24{byte_c[7]}}, byte_c};
      T_BYTEU: ld_data_c = {24'h000000, byte_c};
      default: ld_data_c = src_word_c;
    endcase
    if (misalign_c) begin
      ld_data_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      rvalid_q <= bus.mem_r;
      if (bus.mem_r) begin
        rdata_q <= ld_data_c;
        if (ld_cnt_q != '1) begin
          ld_cnt_q <= ld_cnt_q + CNT_W'(1);
        end
      end
      if (st_en_c && (st_cnt_q != '1)) begin
        st_cnt_q <= st_cnt_q + CNT_W'(1);
      end
    end
  end

  // Array content survives reset; stores are only blocked while reset is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
    end else if (st_en_c) begin
      mem_q[idx_c] <= merged_c;
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic        mis_err_q;
  logic [31:0] mis_addr_q;
  logic        mis_hit_c;

  assign mis_hit_c = misalign_c && (bus.mem_r || (bus.mem_w && st_legal_c));

  // Sticky flag keeps the first offending address until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mis_err_q  <= 1'b0;
      mis_addr_q <= '0;
    end else if (mis_hit_c && !mis_err_q) begin
      mis_err_q  <= 1'b1;
      mis_addr_q <= bus.addr;
    end
  end

  assign mis_err  = mis_err_q;
  assign mis_addr = mis_addr_q;
`endif

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign ld_cnt     = ld_cnt_q;
  assign st_cnt     = st_cnt_q;

endmodule
